chess_timer: RTL
================

# chess_timer

Two-player chess countdown clock that generates the packed BCD time word `reg_a` consumed by the seven-segment timer display. It sits directly upstream of the display top: its `reg_a` output drives the display's `reg_a` input, sharing `segclk`. It holds per-player MM:SS in BCD, decrements the active player once per second, switches turns on a move pulse, and flags timeouts.

## Interface
- `TICK_DIV`, default 1000000: `segclk` cycles per one-second tick. Minimum 2.
- `INC_SEC`, default 5: Fischer increment in seconds, 0..59. Used only when `CHESS_TIMER_INC_EN` is defined.
- `segclk`: in, 1 bit. The single clock.
- `reset`: in, 1 bit. Synchronous, active-high.
- `load`: in, 1 bit. Pulse. Loads both players with `init_min`:00.
- `init_min`: in, 8 bits. Initial minutes, 2 BCD digits, 00..99.
- `start`: in, 1 bit. Pulse. IDLE/PAUSE -> RUN.
- `pause`: in, 1 bit. Pulse. RUN -> PAUSE.
- `move_done`: in, 1 bit. Pulse. The active player has finished a move.
- `reg_a`: out, 32 bits. `[31:16]` is player 1 MMSS, `[15:0]` is player 0 MMSS. 8 BCD digits, most-significant digit first.
- `turn`: out, 1 bit. Active player.
- `running`: out, 1 bit. High in RUN.
- `timeout`: out, 2 bits. Bit n is sticky; player n ran out of time.

## Operation
- States:
  - IDLE: after reset or load.
  - RUN: the active player decrements.
  - PAUSE: frozen.
  - TIMEOUT: terminal until `load` or `reset`.
- Reset values: `reg_a`=0, `turn`=0, `running`=0, `timeout`=0, state IDLE, prescaler 0.
- `load`:
  - Accepted in any state. Highest priority after `reset`.
  - Both players become `init_min`:00; `turn`=0; `timeout`=0; prescaler=0; state IDLE.
  - Any `init_min` nibble >9 is clamped to 9.
- `start`:
  - In IDLE or PAUSE, enters RUN.
  - If the active player reads 00:00, it goes to TIMEOUT instead and sets `timeout[turn]`.
  - Ignored in RUN and TIMEOUT.
- `pause`: RUN -> PAUSE. The prescaler value is held, not cleared. Ignored in all other states.
- Prescaler: counts 0..TICK_DIV-1 only in RUN. The tick fires when it wraps from TICK_DIV-1 to 0.
- Tick decrement of the active player, in BCD:
  - S_lo 0 -> 9 with borrow.
  - S_hi 0 -> 5 with borrow.
  - M_lo 0 -> 9 with borrow.
  - M_hi decrements.
- Timeout: a tick taking the active player to 00:00 sets `timeout[turn]` and enters TIMEOUT.
- `move_done` in RUN (with no simultaneous timeout):
  - `turn` toggles.
  - Prescaler clears to 0.
  - If `CHESS_TIMER_INC_EN` is defined, INC_SEC is added to the mover's time.
  - Ignored in IDLE, PAUSE and TIMEOUT.
- Increment arithmetic:
  - BCD seconds add with carry into minutes.
  - The result saturates at 99:59.
- Same-cycle rules:
  - tick + `move_done`: the tick is applied to the mover first, then the increment, then the turn switch.
  - tick reaches 00:00 + `move_done`: timeout wins. `move_done` is dropped, `turn` is unchanged, no increment.
  - `pause` + `move_done` in RUN: both take effect. The turn switches and the state is PAUSE.
  - `start` + `pause` in PAUSE: `start` wins.
- The inactive player's time never changes except through load or increment.

## Timing
- All outputs are registered.
- `reg_a` updates 1 cycle after the tick cycle, or 1 cycle after the `load` / `move_done` cycle.
- `turn`, `running` and `timeout` update 1 cycle after the causing input.
- First tick after entering RUN from IDLE arrives TICK_DIV cycles after the `start` cycle.
- After `move_done`, the new player's first tick arrives TICK_DIV cycles later.
- Inputs are single-cycle pulses synchronous to `segclk`. A level held high acts once per cycle, with the same rules applied each cycle.

## Configuration
- Macro `CHESS_TIMER_INC_EN`.
- Defined: a Fischer increment of INC_SEC seconds is added to the mover on every accepted `move_done`, saturating at 99:59.
- Undefined: no increment logic is built; `move_done` only switches the turn and clears the prescaler. INC_SEC is ignored.

## Structure
- Package `chess_timer_pkg`:
  - State enum: IDLE, RUN, PAUSE, TIMEOUT.
  - MMSS BCD field offsets.
  - The 99:59 saturation constant.
- Sub-module `chess_timer_bcd_cnt`, instantiated once per player:
  - 16-bit MMSS register.
  - BCD decrement with a zero flag.
  - Load port.
  - Optional saturating BCD add port (under the macro).
- Top level holds:
  - FSM.
  - Prescaler.
  - Turn register.
  - Timeout flags.
  - `reg_a` concatenation.

## Test plan
Use TICK_DIV=4, INC_SEC=5.
- Reset: `reset`=1 -> `reg_a`=0x00000000, `turn`=0, `running`=0, `timeout`=0.
- Load + run: `load` with `init_min`=0x10, then `start` -> after 1 tick `reg_a`=0x10000959; after 60 ticks 0x10000900.
- Borrow chain: load 0x01, run 61 ticks -> player 0 reaches 00:00 on tick 60; `timeout`=2'b01, `running`=0, state TIMEOUT. Further `start`/`move_done` are ignored.
- Turn switch: `move_done` mid-second -> `turn`=1, prescaler cleared, player 0 frozen; player 1 decrements 4 cycles later. With the macro, player 0 gains 5 s (e.g. 09:58 -> 10:03).
- Pause/resume: `pause` at prescaler=2, wait 20 cycles with no change, `start` -> next tick after 2 more cycles.
- Collisions: tick + `move_done` at 00:01 -> timeout, no turn switch. Increment at 99:58 -> 99:59. Load with `init_min`=0xAF -> 99:00.

Source files
------------

// File: rtl/chess_timer_pkg.sv
// Shared types, MMSS field layout and BCD arithmetic helpers for the chess clock.
// Optional Fischer increment is enabled with macro CHESS_TIMER_INC_EN.
package chess_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam int SL_LSB = 0;
    localparam int SH_LSB = 4;
    localparam int ML_LSB = 8;
    localparam int MH_LSB = 12;

    localparam logic [15:0] MMSS_MAX = 16'h9959;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // One-second BCD countdown; 00:00 stays at 00:00.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] sl, sh, ml, mh;
        sl = v[SL_LSB +: 4];
        sh = v[SH_LSB +: 4];
        ml = v[ML_LSB +: 4];
        mh = v[MH_LSB +: 4];
        if (v == 16'h0000) begin
            return v;
        end
        if (sl != 4'd0) begin
            sl = sl - 4'd1;
        end else begin
            sl = 4'd9;
            if (sh != 4'd0) begin
                sh = sh - 4'd1;
            end else begin
                sh = 4'd5;
                if (ml != 4'd0) begin
                    ml = ml - 4'd1;
                end else begin
                    ml = 4'd9;
                    mh = mh - 4'd1;
                end
            end
        end
        return {mh, ml, sh, sl};
    endfunction

    // Adds 0..59 seconds with carry into minutes, saturating at 99:59.
    function automatic logic [15:0] bcd_add_sat(input logic [15:0] v, input logic [5:0] secs);
        logic [4:0] u, t, ml, mh;
        logic [3:0] su, st;
        su = 4'(secs % 6'd10);
        st = 4'(secs / 6'd10);
        u  = {1'b0, v[SL_LSB +: 4]} + {1'b0, su};
        t  = {1'b0, v[SH_LSB +: 4]} + {1'b0, st};
        ml = {1'b0, v[ML_LSB +: 4]};
        mh = {1'b0, v[MH_LSB +: 4]};
        if (u > 5'd9) begin
            u = u - 5'd10;
            t = t + 5'd1;
        end
        if (t > 5'd5) begin
            t  = t - 5'd6;
            ml = ml + 5'd1;
        end
        if (ml > 5'd9) begin
            ml = ml - 5'd10;
            mh = mh + 5'd1;
        end
        if (mh > 5'd9) begin
            return MMSS_MAX;
        end
        return {mh[3:0], ml[3:0], t[3:0], u[3:0]};
    endfunction

endpackage

// File: rtl/chess_timer_bcd_cnt.sv
// Per-player MMSS BCD register with load, countdown and (under CHESS_TIMER_INC_EN)
// a saturating increment applied after the countdown in the same cycle.
module chess_timer_bcd_cnt
    import chess_timer_pkg::*;
`ifdef CHESS_TIMER_INC_EN
#(
    parameter int unsigned INC_SEC = 5
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        dec,
`ifdef CHESS_TIMER_INC_EN
    input  logic        inc,
`endif
    output logic [15:0] value,
    output logic        zero,
    output logic        dec_zero
);

    logic [15:0] value_reg;
    logic [15:0] value_next;
    logic [15:0] dec_val;

    assign dec_val = bcd_dec(value_reg);

    always_comb begin
        value_next = dec ? dec_val : value_reg;
`ifdef CHESS_TIMER_INC_EN
        if (inc) begin
            value_next = bcd_add_sat(value_next, 6'(INC_SEC));
        end
`endif
        if (load) begin
            value_next = load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_reg <= '0;
        end else begin
            value_reg <= value_next;
        end
    end

    assign value    = value_reg;
    assign zero     = (value_reg == 16'h0000);
    assign dec_zero = (dec_val == 16'h0000);

endmodule

// File: rtl/chess_timer.sv
// Two-player chess countdown clock producing the packed BCD display word reg_a.
// Macro CHESS_TIMER_INC_EN adds a Fischer increment of INC_SEC to each mover.
module chess_timer
    import chess_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1000000,
    parameter int unsigned INC_SEC  = 5
) (
    input  logic        segclk,
    input  logic        reset,
    input  logic        load,
    input  logic [7:0]  init_min,
    input  logic        start,
    input  logic        pause,
    input  logic        move_done,
    output logic [31:0] reg_a,
    output logic        turn,
    output logic        running,
    output logic [1:0]  timeout
);

    localparam int PW = $clog2(TICK_DIV);

    state_t          state_reg, state_next;
    logic [PW-1:0]   presc_reg, presc_next;
    logic            turn_reg, turn_next;
    logic [1:0]      timeout_reg, timeout_next;
    logic            running_reg;
    logic            tick;
    logic [1:0]      dec_en;
    logic [1:0]      zero_vec;
    logic [1:0]      dec_zero_vec;
    logic [15:0]     mmss [2];
    logic [15:0]     load_val;
`ifdef CHESS_TIMER_INC_EN
    logic [1:0]      inc_en;
`endif

    assign load_val = {clamp_digit(init_min[7:4]), clamp_digit(init_min[3:0]), 8'h00};

    // A pause in the wrap cycle freezes the prescaler at its last value, so no tick is lost.
    assign tick = (state_reg == ST_RUN) && !pause && (presc_reg == PW'(TICK_DIV - 1));

    for (genvar gi = 0; gi < 2; gi++) begin : g_player
        chess_timer_bcd_cnt
`ifdef CHESS_TIMER_INC_EN
            #(.INC_SEC(INC_SEC))
`endif
            u_cnt (
                .clk      (segclk),
                .reset    (reset),
                .load     (load),
                .load_val (load_val),
                .dec      (dec_en[gi]),
`ifdef CHESS_TIMER_INC_EN
                .inc      (inc_en[gi]),
`endif
                .value    (mmss[gi]),
                .zero     (zero_vec[gi]),
                .dec_zero (dec_zero_vec[gi])
            );
    end

    always_comb begin
        state_next   = state_reg;
        presc_next   = presc_reg;
        turn_next    = turn_reg;
        timeout_next = timeout_reg;
        dec_en       = '0;
`ifdef CHESS_TIMER_INC_EN
        inc_en       = '0;
`endif
        if (load) begin
            state_next   = ST_IDLE;
            presc_next   = '0;
            turn_next    = 1'b0;
            timeout_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_PAUSE: begin
                    if (start) begin
                        if (zero_vec[turn_reg]) begin
                            state_next              = ST_TIMEOUT;
                            timeout_next[turn_reg]  = 1'b1;
                        end else begin
                            state_next = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (!pause) begin
                        presc_next = tick ? '0 : presc_reg + 1'b1;
                    end
                    dec_en[turn_reg] = tick;
                    if (tick && dec_zero_vec[turn_reg]) begin
                        state_next             = ST_TIMEOUT;
                        timeout_next[turn_reg] = 1'b1;
                    end else begin
                        if (move_done) begin
                            turn_next  = ~turn_reg;
                            presc_next = '0;
`ifdef CHESS_TIMER_INC_EN
                            inc_en[turn_reg] = 1'b1;
`endif
                        end
                        if (pause) begin
                            state_next = ST_PAUSE;
                        end
                    end
                end
                ST_TIMEOUT: begin
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge segclk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            presc_reg   <= '0;
            turn_reg    <= 1'b0;
            timeout_reg <= '0;
            running_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            presc_reg   <= presc_next;
            turn_reg    <= turn_next;
            timeout_reg <= timeout_next;
            running_reg <= (state_next == ST_RUN);
        end
    end

    assign reg_a   = {mmss[1], mmss[0]};
    assign turn    = turn_reg;
    assign running = running_reg;
    assign timeout = timeout_reg;

endmodule
